// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared FSM encoding, default sizing and request record for the memory responder.
package mem_resp_pkg;
  localparam int DEPTH_DEF = 64;
  localparam int WAIT_DEF = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: word storage with single write port, combinational read and async clear on reset.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  always_ff @(posedge clk or negedge reset)
    if (!reset) mem_q <= '{default: '0};
    else if (we_i) mem_q[idx_i] <= wdata_i;
  assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: valid/ready memory slave with WAIT_CYCLES wait states; address error checking
// is enabled by defining MEM_RESP_ERR_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t req_q, req_d, in_req, cur_req;
  logic [31:0] rdata_q, rdata_d, mem_rdata;
  logic err_q, err_d, accept, enter_resp, bad, we;
  assign in_req = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign accept = req_valid && state_q == ST_IDLE;
  // With zero wait states the request completes on its accepting edge, before req_q holds it.
  assign cur_req = state_q == ST_IDLE ? in_req : req_q;
  assign enter_resp = (accept && WAIT_CYCLES == 0) || (state_q == ST_WAIT && cnt_q == 4'd0);
`ifdef MEM_RESP_ERR_EN
  assign bad = cur_req.addr[1:0] != 2'b00 || (cur_req.addr >> 2) >= 32'(DEPTH);
`else
  logic unused_addr;
  assign unused_addr = ^{cur_req.addr[31:AW+2], cur_req.addr[1:0]};
  assign bad = 1'b0;
`endif
  assign we = enter_resp && cur_req.write && !bad;
  mem_resp_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk(clk),
    .reset(reset),
    .we_i(we),
    .idx_i(cur_req.addr[AW+1:2]),
    .wdata_i(cur_req.wdata),
    .rdata_o(mem_rdata)
  );
  always_comb begin
    state_d = accept ? (WAIT_CYCLES == 0 ? ST_RESP : ST_WAIT)
            : state_q == ST_WAIT ? (cnt_q == 4'd0 ? ST_RESP : ST_WAIT)
            : (state_q == ST_RESP && resp_ready) ? ST_IDLE : state_q;
    cnt_d = (accept && WAIT_CYCLES != 0) ? 4'(WAIT_CYCLES - 1)
          : (state_q == ST_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    req_d = accept ? in_req : req_q;
    rdata_d = enter_resp ? ((bad || cur_req.write) ? 32'd0 : mem_rdata) : rdata_q;
    err_d = enter_resp ? bad : err_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      req_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  assign req_ready = state_q == ST_IDLE;
  assign resp_valid = state_q == ST_RESP;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (WAIT_CYCLES=2) plus a zero-wait instance.
module tb_mem_responder;
  localparam int W = 2;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  logic req_valid = 0, req_write = 0, resp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic z_valid = 0, z_write = 0;
  logic [31:0] z_addr = 0, z_wdata = 0;
  logic z_ready, z_resp_valid, z_err;
  logic [31:0] z_rdata;
  mem_responder #(.DEPTH(64), .WAIT_CYCLES(W)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err));
  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .req_valid(z_valid), .req_ready(z_ready),
    .req_write(z_write), .req_addr(z_addr), .req_wdata(z_wdata),
    .resp_valid(z_resp_valid), .resp_ready(1'b1), .resp_rdata(z_rdata), .resp_err(z_err));
  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0, acc_cyc = 0;
  bit first = 0;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // Monitor: measures acceptance-to-response latency and scores every presented response.
  always @(negedge clk) begin
    if (!reset) first = 0;
    else begin
      if (req_valid && req_ready) begin acc_cyc = cyc + 1; first = 1; end
      if (resp_valid) begin
        check("busy_req_ready", req_ready, 0);
        if (first) begin check("latency", cyc - acc_cyc + 1, W + 1); first = 0; end
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got rdata %h with nothing outstanding", resp_rdata);
        end else begin
          check("rdata", resp_rdata, sb[0].rdata);
          check("err", resp_err, sb[0].err);
          if (resp_ready) void'(sb.pop_front());
        end
      end
    end
  end
  task automatic issue(input logic w, input logic [31:0] a, d, er, input logic ee, input bit push);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("accept_timeout", req_ready, 1);
    @(posedge clk);
    if (push) sb.push_back('{er, ee});
    #1 req_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    check("drain", sb.size(), 0);
  endtask
  task automatic req(input logic w, input logic [31:0] a, d, er, input logic ee);
    issue(w, a, d, er, ee, 1);
    drain();
  endtask
  task automatic zreq(input logic w, input logic [31:0] a, d, er);
    @(posedge clk); #1;
    z_valid = 1; z_write = w; z_addr = a; z_wdata = d;
    @(negedge clk);
    check("z_req_ready", z_ready, 1);
    @(posedge clk); #1 z_valid = 0;
    @(negedge clk);
    check("z_resp_valid", z_resp_valid, 1);
    check("z_rdata", z_rdata, er);
    check("z_busy", z_ready, 0);
    @(negedge clk);
    check("z_idle", z_resp_valid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1);
    zreq(0, 32'h0, 0, 32'h0);
    zreq(1, 32'h4, 32'h5, 32'h0);
    zreq(0, 32'h4, 0, 32'h5);
    req(1, 32'h10, 32'hDEADBEEF, 0, 0);
    req(0, 32'h10, 0, 32'hDEADBEEF, 0);
    req(1, 32'h20, 32'hA5A50F0F, 0, 0);
    resp_ready = 0;
    issue(0, 32'h20, 0, 32'hA5A50F0F, 0, 1);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    check("stall_resp_seen", resp_valid, 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 resp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    check("idle_after_hs", req_ready, 1);
    check("valid_after_hs", resp_valid, 0);
    drain();
    issue(1, 32'h8, 32'h12345678, 0, 0, 0);
    #2 reset = 0;
    @(negedge clk);
    check("midrst_valid", resp_valid, 0);
    check("midrst_rdata", resp_rdata, 0);
    @(posedge clk); #1 reset = 1;
    repeat (6) begin @(negedge clk); check("no_resp", resp_valid, 0); end
    req(0, 32'h8, 0, 32'h0, 0);
    req(0, 32'h10, 0, 32'h0, 0);
    req(1, 32'h0, 32'h11111111, 0, 0);
`ifdef MEM_RESP_ERR_EN
    req(0, 32'h3, 0, 32'h0, 1);
    req(1, 32'h100, 32'h22222222, 0, 1);
    req(0, 32'h0, 0, 32'h11111111, 0);
`else
    req(0, 32'h3, 0, 32'h11111111, 0);
    req(1, 32'h100, 32'h22222222, 0, 0);
    req(0, 32'h0, 0, 32'h22222222, 0);
`endif
    req(1, 32'hFC, 32'hCAFEF00D, 0, 0);
    req(0, 32'hFC, 0, 32'hCAFEF00D, 0);
    req(0, 32'hF8, 0, 32'h0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words stored (power of two, at least 2).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted between request acceptance and response (range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: the CPU-side initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address (ALU result).
REQ-009 SHALL have port req_wdata, input, 32 bits: store data.
REQ-010 SHALL have port resp_valid, output, 1 bit: a response is presented.
REQ-011 SHALL have port resp_ready, input, 1 bit: the initiator accepts the response.
REQ-012 SHALL have port resp_rdata, output, 32 bits: load data; 0 for stores.
REQ-013 SHALL have port resp_err, output, 1 bit: error status of the response (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-015 SHALL accept a request on the rising edge where req_valid && req_ready, capturing req_write, req_addr and req_wdata.
REQ-016 SHALL go IDLE->RESP when WAIT_CYCLES = 0, else IDLE->WAIT with a 4-bit counter loaded to WAIT_CYCLES-1.
REQ-017 SHALL, in WAIT, decrement the counter each cycle and move to RESP on the edge where the counter is 0.
REQ-018 SHALL assert resp_valid exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-019 SHALL perform the store, and register the load data into resp_rdata, on the edge entering RESP.
REQ-020 SHALL use word index req_addr[log2(DEPTH)+1:2]; upper address bits are ignored unless MEM_RESP_ERR_EN is defined.
REQ-021 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready = 1, then return to IDLE on that edge.
REQ-022 SHALL ignore req_valid outside IDLE, so a back-to-back request is accepted no earlier than the cycle after the response handshake.
REQ-023 SHALL return load-after-store data from the same address with the stored value, with no stale read.

Reset
REQ-024 SHALL, on reset low, immediately force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0 and all memory words to 0.
REQ-025 SHALL abandon a request in flight if reset asserts mid-operation (WAIT or RESP): no store is performed and no response is issued.
REQ-026 SHALL present req_ready = 1 in the first cycle after reset deasserts.

Configuration
REQ-027 SHALL, when MEM_RESP_ERR_EN is defined, flag a misaligned request (req_addr[1:0] != 0) or out-of-range request (req_addr >> 2 >= DEPTH) with resp_err = 1, resp_rdata = 0 and no store.
REQ-028 SHALL, when MEM_RESP_ERR_EN is undefined, tie resp_err to 0 and perform no address checking.

Structure
REQ-029 SHALL take the state encoding (IDLE/WAIT/RESP) and the default DEPTH/WAIT_CYCLES constants from a shared package mem_resp_pkg.
REQ-030 SHALL place the storage array and its reset-clear logic in one sub-module, mem_resp_array; the FSM, counter and handshake logic stay in mem_responder.

Verification
REQ-031 SHALL cover: store 0xDEADBEEF at 0x10, then load 0x10 with resp_ready=1 -> resp_rdata = 0xDEADBEEF, resp_valid exactly 3 cycles after each acceptance (WAIT_CYCLES=2).
REQ-032 SHALL cover: with WAIT_CYCLES=0, load 0x0 after reset -> resp_valid on the next cycle with resp_rdata = 0.
REQ-033 SHALL cover: hold resp_ready=0 for 5 cycles during a load of 0x20 -> resp_valid and resp_rdata stay stable and req_ready=0 throughout; IDLE one cycle after resp_ready rises.
REQ-034 SHALL cover: assert reset in the WAIT state of a store of 0x12345678 to 0x8 -> no response, and a later load of 0x8 returns 0.
REQ-035 SHALL cover, with MEM_RESP_ERR_EN defined: load 0x3, and store to 0x100 with DEPTH=64 -> resp_err=1 with rdata 0, and the word at index 0 is unchanged.
